// File: rtl/doc_reg_bank.sv
// doc5503 oscillator register bank: host 8-bit register map, engine read/writeback port, interrupt FIFO.
// Latency: host reads and engine reads are 1 cycle (registered); num_osc_o is combinational from osc_en.
// Backpressure: none; a push into a full interrupt FIFO is dropped and latched as status overflow.

module sync_fifo #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 8
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic                       in_vld,
   output logic                       in_rdy,
   input  logic [WIDTH-1:0]           in_dat,
   output logic                       out_vld,
   input  logic                       out_rdy,
   output logic [WIDTH-1:0]           out_dat,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push;
   logic             pop;

   assign in_rdy  = (count != (AW+1)'(DEPTH));
   assign out_vld = (count != '0);
   assign out_dat = mem[rd_ptr];
   assign push    = in_vld & in_rdy;
   assign pop     = out_vld & out_rdy;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= in_dat;
   end
endmodule

module doc_reg_bank #(
   parameter int         NUM_OSC      = 32,
   parameter int         IRQ_DEPTH    = 8,
   parameter logic [7:0] CTRL_RESET   = 8'h01,
   parameter logic [7:0] OSC_EN_RESET = 8'h02
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        cs_n_i,
   input  logic        we_n_i,
   input  logic [7:0]  addr_i,
   input  logic [7:0]  data_i,
   output logic [7:0]  data_o,
   output logic        irq_n_o,
   input  logic [4:0]  eng_osc_i,
   output logic [15:0] eng_freq_o,
   output logic [7:0]  eng_vol_o,
   output logic [7:0]  eng_ptr_o,
   output logic [7:0]  eng_ctrl_o,
   output logic [7:0]  eng_rts_o,
   input  logic        eng_we_i,
   input  logic [7:0]  eng_ctrl_i,
   input  logic [7:0]  eng_sample_i,
   input  logic        irq_req_i,
   input  logic [4:0]  irq_osc_i,
   output logic [5:0]  num_osc_o
);
   localparam int CW = $clog2(IRQ_DEPTH) + 1;

   logic [7:0] freq_lo [NUM_OSC];
   logic [7:0] freq_hi [NUM_OSC];
   logic [7:0] vol     [NUM_OSC];
   logic [7:0] sample  [NUM_OSC];
   logic [7:0] ptr     [NUM_OSC];
   logic [7:0] ctrl    [NUM_OSC];
   logic [7:0] rts     [NUM_OSC];
   logic [7:0] osc_en;
   logic       ovf;

   logic       cs_q;
   logic       strobe;
   logic       host_wr;
   logic       host_rd;
   logic [2:0] grp;
   logic [4:0] idx;
   logic [7:0] osc_rd;
   logic [7:0] glb_rd;
   logic [7:0] rd_val;

   logic       irq_ie;
   logic       fifo_in_vld;
   logic       fifo_in_rdy;
   logic       fifo_out_vld;
   logic       fifo_out_rdy;
   logic [4:0] fifo_out_dat;
   logic [CW-1:0] fifo_cnt;
   logic       push_ok;
   logic       pop_ok;
   logic [5:0] osc_sum;

   logic [15:0] eng_freq_nxt;
   logic [7:0]  eng_vol_nxt;
   logic [7:0]  eng_ptr_nxt;
   logic [7:0]  eng_ctrl_nxt;
   logic [7:0]  eng_rts_nxt;

   // cs_q resets low so an access in progress at reset must see cs_n_i high before re-arming.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) cs_q <= 1'b0;
      else            cs_q <= cs_n_i;
   end

   assign strobe  = ~cs_n_i & cs_q;
   assign host_wr = strobe & ~we_n_i;
   assign host_rd = strobe & we_n_i;
   assign grp     = addr_i[7:5];
   assign idx     = addr_i[4:0];

   // Engine writeback first, host write last, so the host wins on a same-register collision.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < NUM_OSC; i++) begin
            freq_lo[i] <= 8'h00;
            freq_hi[i] <= 8'h00;
            vol[i]     <= 8'h00;
            sample[i]  <= 8'h00;
            ptr[i]     <= 8'h00;
            ctrl[i]    <= CTRL_RESET;
            rts[i]     <= 8'h00;
         end
      end else begin
         for (int i = 0; i < NUM_OSC; i++) begin
            if (eng_we_i && eng_osc_i == 5'(i)) begin
               ctrl[i]   <= eng_ctrl_i;
               sample[i] <= eng_sample_i;
            end
            if (host_wr && idx == 5'(i)) begin
               case (grp)
                  3'd0:    freq_lo[i] <= data_i;
                  3'd1:    freq_hi[i] <= data_i;
                  3'd2:    vol[i]     <= data_i;
                  3'd3:    sample[i]  <= data_i;
                  3'd4:    ptr[i]     <= data_i;
                  3'd5:    ctrl[i]    <= data_i;
                  3'd6:    rts[i]     <= data_i;
                  default: ;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         osc_en <= OSC_EN_RESET;
         ovf    <= 1'b0;
      end else begin
         if (host_wr && addr_i == 8'hE1) osc_en <= data_i;
         ovf <= (fifo_in_vld & ~fifo_in_rdy) | (ovf & ~(host_rd && addr_i == 8'hE2));
      end
   end

   always_comb begin
      osc_rd = 8'h00;
      for (int i = 0; i < NUM_OSC; i++) begin
         if (idx == 5'(i)) begin
            case (grp)
               3'd0:    osc_rd = freq_lo[i];
               3'd1:    osc_rd = freq_hi[i];
               3'd2:    osc_rd = vol[i];
               3'd3:    osc_rd = sample[i];
               3'd4:    osc_rd = ptr[i];
               3'd5:    osc_rd = ctrl[i];
               3'd6:    osc_rd = rts[i];
               default: osc_rd = 8'h00;
            endcase
         end
      end
   end

   always_comb begin
      glb_rd = 8'h00;
      case (idx)
         5'd0:    glb_rd = fifo_out_vld ? {2'b01, fifo_out_dat, 1'b1} : 8'hFF;
         5'd1:    glb_rd = osc_en;
         5'd2:    glb_rd = {7'b0, ovf};
         default: glb_rd = 8'h00;
      endcase
   end

   assign rd_val = (grp == 3'd7) ? glb_rd : osc_rd;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)   data_o <= 8'h00;
      else if (host_rd) data_o <= rd_val;
   end

   always_comb begin
      eng_freq_nxt = 16'h0000;
      eng_vol_nxt  = 8'h00;
      eng_ptr_nxt  = 8'h00;
      eng_ctrl_nxt = 8'h00;
      eng_rts_nxt  = 8'h00;
      irq_ie       = 1'b0;
      for (int i = 0; i < NUM_OSC; i++) begin
         if (eng_osc_i == 5'(i)) begin
            eng_freq_nxt = {freq_hi[i], freq_lo[i]};
            eng_vol_nxt  = vol[i];
            eng_ptr_nxt  = ptr[i];
            eng_ctrl_nxt = ctrl[i];
            eng_rts_nxt  = rts[i];
         end
         if (irq_osc_i == 5'(i)) irq_ie = ctrl[i][3];
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         eng_freq_o <= 16'h0000;
         eng_vol_o  <= 8'h00;
         eng_ptr_o  <= 8'h00;
         eng_ctrl_o <= 8'h00;
         eng_rts_o  <= 8'h00;
      end else begin
         eng_freq_o <= eng_freq_nxt;
         eng_vol_o  <= eng_vol_nxt;
         eng_ptr_o  <= eng_ptr_nxt;
         eng_ctrl_o <= eng_ctrl_nxt;
         eng_rts_o  <= eng_rts_nxt;
      end
   end

   // Unimplemented oscillators never match the loop above, so irq_ie stays 0 for them.
   assign fifo_in_vld  = irq_req_i & irq_ie;
   assign fifo_out_rdy = host_rd && addr_i == 8'hE0;
   assign push_ok      = fifo_in_vld & fifo_in_rdy;
   assign pop_ok       = fifo_out_rdy & fifo_out_vld;

   sync_fifo #(.WIDTH(5), .DEPTH(IRQ_DEPTH)) u_irq_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .in_vld    (fifo_in_vld),
      .in_rdy    (fifo_in_rdy),
      .in_dat    (irq_osc_i),
      .out_vld   (fifo_out_vld),
      .out_rdy   (fifo_out_rdy),
      .out_dat   (fifo_out_dat),
      .count     (fifo_cnt)
   );

   // irq_n_o tracks the FIFO occupancy that results from this edge.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) irq_n_o <= 1'b1;
      else irq_n_o <= ((fifo_cnt == '0) && !push_ok) ||
                      ((fifo_cnt == CW'(1)) && pop_ok && !push_ok);
   end

   assign osc_sum   = {1'b0, osc_en[5:1]} + 6'd1;
   assign num_osc_o = (osc_sum > 6'(NUM_OSC)) ? 6'(NUM_OSC) : osc_sum;
endmodule

// File: tb/tb_doc_reg_bank.sv
// Randomised scoreboard bench for doc_reg_bank against a register-map reference model.
module tb_doc_reg_bank;
   localparam int NUM   = 32;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic        cs_n = 1'b1, we_n = 1'b1, cs16_n = 1'b1;
   logic [7:0]  addr = 8'h00, data = 8'h00;
   logic [7:0]  data_o, data16;
   logic        irq_n, irq16_n;
   logic [4:0]  eng_osc = 5'd0;
   logic [15:0] eng_freq, e16_freq;
   logic [7:0]  eng_vol, eng_ptr, eng_ctrl, eng_rts;
   logic [7:0]  e16_vol, e16_ptr, e16_ctrl, e16_rts;
   logic        eng_we = 1'b0;
   logic [7:0]  eng_ctrl_in = 8'h00, eng_sample = 8'h00;
   logic        irq_req = 1'b0;
   logic [4:0]  irq_osc = 5'd0;
   logic [5:0]  num_osc, num16;

   doc_reg_bank dut (
      .clk_i(clk), .reset_n_i(reset_n), .cs_n_i(cs_n), .we_n_i(we_n), .addr_i(addr),
      .data_i(data), .data_o(data_o), .irq_n_o(irq_n), .eng_osc_i(eng_osc),
      .eng_freq_o(eng_freq), .eng_vol_o(eng_vol), .eng_ptr_o(eng_ptr), .eng_ctrl_o(eng_ctrl),
      .eng_rts_o(eng_rts), .eng_we_i(eng_we), .eng_ctrl_i(eng_ctrl_in), .eng_sample_i(eng_sample),
      .irq_req_i(irq_req), .irq_osc_i(irq_osc), .num_osc_o(num_osc));

   doc_reg_bank #(.NUM_OSC(16)) dut16 (
      .clk_i(clk), .reset_n_i(reset_n), .cs_n_i(cs16_n), .we_n_i(we_n), .addr_i(addr),
      .data_i(data), .data_o(data16), .irq_n_o(irq16_n), .eng_osc_i(eng_osc),
      .eng_freq_o(e16_freq), .eng_vol_o(e16_vol), .eng_ptr_o(e16_ptr), .eng_ctrl_o(e16_ctrl),
      .eng_rts_o(e16_rts), .eng_we_i(eng_we), .eng_ctrl_i(eng_ctrl_in), .eng_sample_i(eng_sample),
      .irq_req_i(irq_req), .irq_osc_i(irq_osc), .num_osc_o(num16));

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: field groups x oscillators, globals, and a queue of pending interrupts.
   logic [7:0] m_reg [7][32];
   logic [7:0] m_osc_en;
   bit         m_ovf;
   int         m_q[$];

   function automatic void model_reset();
      for (int g = 0; g < 7; g++)
         for (int i = 0; i < 32; i++) m_reg[g][i] = (g == 5) ? 8'h01 : 8'h00;
      m_osc_en = 8'h02;
      m_ovf = 0;
      m_q.delete();
   endfunction

   function automatic logic [7:0] model_read(input logic [7:0] a);
      int g = int'(a[7:5]);
      int i = int'(a[4:0]);
      if (g < 7) return (i < NUM) ? m_reg[g][i] : 8'h00;
      case (i)
         0: return (m_q.size() == 0) ? 8'hFF : 8'(8'h41 + m_q[0] * 2);
         1: return m_osc_en;
         2: return {7'b0, m_ovf};
         default: return 8'h00;
      endcase
   endfunction

   function automatic void model_read_effects(input logic [7:0] a);
      if (a == 8'hE0 && m_q.size() > 0) void'(m_q.pop_front());
      if (a == 8'hE2) m_ovf = 0;
   endfunction

   function automatic void model_write(input logic [7:0] a, input logic [7:0] d);
      if (a[7:5] != 3'd7) begin
         if (int'(a[4:0]) < NUM) m_reg[a[7:5]][a[4:0]] = d;
      end else if (a == 8'hE1) m_osc_en = d;
   endfunction

   function automatic void model_irq(input int o);
      if (o < NUM && m_reg[5][o][3]) begin
         if (m_q.size() == DEPTH) m_ovf = 1;
         else m_q.push_back(o);
      end
   endfunction

   function automatic int model_num();
      int v = int'(m_osc_en[5:1]) + 1;
      return (v > NUM) ? NUM : v;
   endfunction

   logic [7:0] exp_q[$];
   bit rd_issue = 0;

   initial forever begin
      @(posedge clk);
      if (rd_issue) begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL host_rd: got %0h with no expected value queued", data_o);
         end else check("host_rd", data_o, exp_q.pop_front());
      end
   end

   task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
      @(posedge clk); #1 cs_n = 0; we_n = 0; addr = a; data = d;
      @(posedge clk); #1 cs_n = 1; we_n = 1; model_write(a, d);
   endtask

   task automatic host_rd(input logic [7:0] a);
      @(posedge clk); #1 cs_n = 0; we_n = 1; addr = a;
      exp_q.push_back(model_read(a)); model_read_effects(a); rd_issue = 1;
      @(posedge clk); #1 cs_n = 1; rd_issue = 0;
   endtask

   task automatic pulse_irq(input logic [4:0] o);
      @(posedge clk); #1 irq_req = 1; irq_osc = o; model_irq(int'(o));
      @(posedge clk); #1 irq_req = 0;
   endtask

   task automatic eng_wb(input logic [4:0] o, input logic [7:0] c, input logic [7:0] s);
      @(posedge clk); #1 eng_we = 1; eng_osc = o; eng_ctrl_in = c; eng_sample = s;
      if (int'(o) < NUM) begin m_reg[5][o] = c; m_reg[3][o] = s; end
      @(posedge clk); #1 eng_we = 0;
   endtask

   task automatic check_eng(input logic [4:0] o);
      @(posedge clk); #1 eng_osc = o;
      @(posedge clk); @(negedge clk);
      check("eng_freq", eng_freq, {m_reg[1][o], m_reg[0][o]});
      check("eng_vol",  eng_vol,  m_reg[2][o]);
      check("eng_ptr",  eng_ptr,  m_reg[4][o]);
      check("eng_ctrl", eng_ctrl, m_reg[5][o]);
      check("eng_rts",  eng_rts,  m_reg[6][o]);
   endtask

   task automatic check_status();
      @(negedge clk);
      check("irq_n", irq_n, (m_q.size() == 0));
      check("num_osc", num_osc, model_num());
   endtask

   task automatic h16(input bit wr, input logic [7:0] a, input logic [7:0] d);
      @(posedge clk); #1 cs16_n = 0; we_n = !wr; addr = a; data = d;
      @(posedge clk); #1 cs16_n = 1; we_n = 1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      #12;
      check("rst_data_o", data_o, 8'h00);
      check("rst_irq_n", irq_n, 1'b1);
      check("rst_eng_ctrl", eng_ctrl, 8'h00);
      check("rst_num_osc", num_osc, 6'd2);
      #10 reset_n = 1;

      host_rd(8'hA3);
      host_rd(8'hE1);
      host_rd(8'hE0);
      check_status();

      // Held chip select: one commit only, later data changes must not land.
      @(posedge clk); #1 cs_n = 0; we_n = 0; addr = 8'h47; data = 8'h80; eng_osc = 5'd7;
      @(posedge clk); #1 data = 8'h11; model_write(8'h47, 8'h80);
      @(negedge clk); check("eng_vol_pre", eng_vol, 8'h00);
      @(negedge clk); check("eng_vol_post", eng_vol, 8'h80);
      repeat (3) @(posedge clk);
      #1 cs_n = 1; we_n = 1;
      host_rd(8'h47);

      host_wr(8'hA3, 8'h08);
      pulse_irq(5'd3);
      check_status();
      host_rd(8'hE0);
      check_status();

      for (int o = 0; o <= DEPTH; o++) host_wr(8'(8'hA0 + o), 8'h08);
      for (int o = 0; o <= DEPTH; o++) pulse_irq(5'(o));
      check_status();
      host_rd(8'hE2);
      host_rd(8'hE2);
      for (int k = 0; k <= DEPTH; k++) host_rd(8'hE0);
      check_status();

      // Host and engine hit osc 5 on the same edge.
      @(posedge clk); #1 cs_n = 0; we_n = 0; addr = 8'hA5; data = 8'h00;
      eng_we = 1; eng_osc = 5'd5; eng_ctrl_in = 8'h01; eng_sample = 8'h5A;
      @(posedge clk); #1 cs_n = 1; we_n = 1; eng_we = 0;
      model_write(8'hA5, 8'h00); m_reg[3][5] = 8'h5A;
      host_rd(8'hA5);
      host_rd(8'h65);

      // Pop of an empty FIFO on the same edge as a push.
      host_wr(8'hA2, 8'h08);
      @(posedge clk); #1 cs_n = 0; we_n = 1; addr = 8'hE0; irq_req = 1; irq_osc = 5'd2;
      exp_q.push_back(model_read(8'hE0)); model_read_effects(8'hE0); model_irq(2); rd_issue = 1;
      @(posedge clk); #1 cs_n = 1; irq_req = 0; rd_issue = 0;
      check_status();
      host_rd(8'hE0);
      check_status();

      for (int n = 0; n < 300; n++) begin
         logic [7:0] a;
         case ($urandom_range(0, 4))
            0: begin
               a = 8'($urandom_range(0, 255));
               if (a == 8'hE0 || a == 8'hE2) a = 8'hE1;
               host_wr(a, 8'($urandom));
            end
            1: host_rd(8'($urandom_range(0, 255)));
            2: pulse_irq(5'($urandom_range(0, 31)));
            3: eng_wb(5'($urandom_range(0, 31)), 8'($urandom), 8'($urandom));
            default: check_eng(5'($urandom_range(0, 31)));
         endcase
         check_status();
      end

      // Asynchronous reset in the middle of a held write.
      @(posedge clk); #1 cs_n = 0; we_n = 0; addr = 8'h40; data = 8'h99;
      @(posedge clk); #2 reset_n = 0;
      #1 check("midrst_irq_n", irq_n, 1'b1);
      check("midrst_data_o", data_o, 8'h00);
      model_reset();
      #3 reset_n = 1;
      repeat (2) @(posedge clk);
      #1 cs_n = 1; we_n = 1;
      host_rd(8'h40);
      host_rd(8'hA0);
      check_status();

      h16(1, 8'hE1, 8'h3E);
      @(negedge clk); check("num16", num16, 6'd16);
      h16(1, 8'h12, 8'h55);
      h16(1, 8'h02, 8'h55);
      h16(0, 8'h12, 8'h00);
      @(negedge clk); check("unimpl_rd", data16, 8'h00);
      h16(0, 8'h02, 8'h00);
      @(negedge clk); check("impl_rd16", data16, 8'h55);

      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
